// File: rtl/ahb_lite_sdram_bus_pkg.sv
// rtl/ahb_lite_sdram_bus_pkg.sv - shared constants, states and alignment helper for the AHB-Lite SDRAM front end
package ahb_lite_sdram_bus_pkg;

  localparam int CMD_WRITE_BIT = 34;
  localparam int CMD_SIZE_LSB  = 32;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WDATA = 3'd1,
    S_RCMD  = 3'd2,
    S_RWAIT = 3'd3,
    S_RDONE = 3'd4,
    S_ERR1  = 3'd5,
    S_ERR2  = 3'd6
  } state_t;

  // Oversized transfers and anything not naturally aligned to its size.
  function automatic logic xfer_illegal(input logic [2:0] size, input logic [1:0] addr_lo);
    return (size > 3'd2) ||
           ((size == 3'd1) && addr_lo[0]) ||
           ((size == 3'd2) && (addr_lo != 2'b00));
  endfunction

endpackage

// File: rtl/ahb_lite_sdram_bus.sv
// rtl/ahb_lite_sdram_bus.sv - AHB-Lite slave feeding the SDRAM cmd/write FIFOs and draining the read FIFO
// Optional alignment/size ERROR responses: AHB_LITE_SDRAM_ERR_EN
module ahb_lite_sdram_bus
  import ahb_lite_sdram_bus_pkg::*;
#(
  parameter int CMD_WIDTH  = 35,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic [31:0]           HADDR,
  input  logic [2:0]            HBURST,
  input  logic                  HSEL,
  input  logic [2:0]            HSIZE,
  input  logic [1:0]            HTRANS,
  input  logic [DATA_WIDTH-1:0] HWDATA,
  input  logic                  HWRITE,
  input  logic                  HREADY,
  output logic [DATA_WIDTH-1:0] HRDATA,
  output logic                  HREADYOUT,
  output logic                  HRESP,
  output logic                  CFIFO_WEN,
  output logic [CMD_WIDTH-1:0]  CFIFO_WDATA,
  input  logic                  CFIFO_WFULL,
  output logic                  WFIFO_WEN,
  output logic [DATA_WIDTH-1:0] WFIFO_WDATA,
  input  logic                  WFIFO_WFULL,
  output logic                  RFIFO_REN,
  input  logic [DATA_WIDTH-1:0] RFIFO_RDATA,
  input  logic                  RFIFO_REMPTY
);

  state_t                r_state;
  state_t                w_next;
  state_t                w_accept_state;
  logic                  r_cmd_write;
  logic [1:0]            r_cmd_size;
  logic [31:0]           r_cmd_addr;
  logic [DATA_WIDTH-1:0] r_hrdata;

  logic w_accept;
  logic w_reject;
  logic w_hreadyout;
  logic w_cwen;
  logic w_wwen;
  logic w_ren;
  logic w_unused;

  assign w_accept = HSEL & HREADY & HTRANS[1];
  assign w_unused = ^{HBURST, HSIZE[2]};

`ifdef AHB_LITE_SDRAM_ERR_EN
  assign w_reject = w_accept & xfer_illegal(HSIZE, HADDR[1:0]);
  assign HRESP    = (r_state == S_ERR1) || (r_state == S_ERR2);
`else
  assign w_reject = 1'b0;
  assign HRESP    = 1'b0;
`endif

  // Destination for a new address phase, shared by every state that ends a transfer.
  always_comb begin
    w_accept_state = S_IDLE;
    if (w_reject)
      w_accept_state = S_ERR1;
    else if (w_accept)
      w_accept_state = HWRITE ? S_WDATA : S_RCMD;
  end

  always_comb begin
    w_next      = r_state;
    w_hreadyout = 1'b1;
    w_cwen      = 1'b0;
    w_wwen      = 1'b0;
    w_ren       = 1'b0;
    case (r_state)
      S_IDLE, S_RDONE, S_ERR2: w_next = w_accept_state;
      S_WDATA: begin
        w_hreadyout = !CFIFO_WFULL && !WFIFO_WFULL;
        if (w_hreadyout) begin
          w_cwen = 1'b1;
          w_wwen = 1'b1;
          w_next = w_accept_state;
        end
      end
      S_RCMD: begin
        w_hreadyout = 1'b0;
        if (!CFIFO_WFULL) begin
          w_cwen = 1'b1;
          w_next = S_RWAIT;
        end
      end
      S_RWAIT: begin
        w_hreadyout = 1'b0;
        if (!RFIFO_REMPTY) begin
          w_ren  = 1'b1;
          w_next = S_RDONE;
        end
      end
      S_ERR1: begin
        w_hreadyout = 1'b0;
        w_next      = S_ERR2;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_state     <= S_IDLE;
      r_cmd_write <= 1'b0;
      r_cmd_size  <= 2'b00;
      r_cmd_addr  <= 32'h0;
      r_hrdata    <= '0;
    end else begin
      r_state <= w_next;
      // The pushed command comes from the old register value, so a pipelined accept may overwrite it here.
      if (w_accept && !w_reject && w_hreadyout) begin
        r_cmd_write <= HWRITE;
        r_cmd_size  <= HSIZE[1:0];
        r_cmd_addr  <= HADDR;
      end
      if (w_ren)
        r_hrdata <= RFIFO_RDATA;
    end
  end

  assign HREADYOUT   = w_hreadyout;
  assign HRDATA      = r_hrdata;
  assign CFIFO_WEN   = w_cwen;
  assign CFIFO_WDATA = {r_cmd_write, r_cmd_size, r_cmd_addr};
  assign WFIFO_WEN   = w_wwen;
  assign WFIFO_WDATA = HWDATA;
  assign RFIFO_REN   = w_ren;

endmodule

// File: tb/tb_ahb_lite_sdram_bus.sv
// tb/tb_ahb_lite_sdram_bus.sv - scoreboard bench for ahb_lite_sdram_bus (error tests need AHB_LITE_SDRAM_ERR_EN)
module tb_ahb_lite_sdram_bus;

  logic        HCLK;
  logic        HRESETn;
  logic [31:0] HADDR;
  logic [2:0]  HBURST;
  logic        HSEL;
  logic [2:0]  HSIZE;
  logic [1:0]  HTRANS;
  logic [31:0] HWDATA;
  logic        HWRITE;
  wire         HREADY;
  logic [31:0] HRDATA;
  logic        HREADYOUT;
  logic        HRESP;
  logic        CFIFO_WEN;
  logic [34:0] CFIFO_WDATA;
  logic        CFIFO_WFULL;
  logic        WFIFO_WEN;
  logic [31:0] WFIFO_WDATA;
  logic        WFIFO_WFULL;
  logic        RFIFO_REN;
  logic [31:0] RFIFO_RDATA;
  logic        RFIFO_REMPTY;

  assign HREADY = HREADYOUT;

  ahb_lite_sdram_bus dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HADDR(HADDR), .HBURST(HBURST), .HSEL(HSEL),
    .HSIZE(HSIZE), .HTRANS(HTRANS), .HWDATA(HWDATA), .HWRITE(HWRITE), .HREADY(HREADY),
    .HRDATA(HRDATA), .HREADYOUT(HREADYOUT), .HRESP(HRESP),
    .CFIFO_WEN(CFIFO_WEN), .CFIFO_WDATA(CFIFO_WDATA), .CFIFO_WFULL(CFIFO_WFULL),
    .WFIFO_WEN(WFIFO_WEN), .WFIFO_WDATA(WFIFO_WDATA), .WFIFO_WFULL(WFIFO_WFULL),
    .RFIFO_REN(RFIFO_REN), .RFIFO_RDATA(RFIFO_RDATA), .RFIFO_REMPTY(RFIFO_REMPTY)
  );

  typedef struct {
    logic        err;
    logic [31:0] data;
  } rd_exp_t;

  logic [34:0] exp_cmd_q[$];
  logic [31:0] exp_wd_q[$];
  rd_exp_t     exp_rd_q[$];
  logic [31:0] rf_data_q[$];

  int n_vec = 0;
  int n_bad = 0;
  int ren_cnt = 0;
  int rd_delay = 0;

  initial begin
    HCLK = 1'b0;
    forever #5 HCLK = ~HCLK;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic flag_fail(input string name);
    n_vec++;
    n_bad++;
    $display("FAIL %s: got unexpected event expected none at %0t", name, $time);
  endtask

  // Scoreboard monitor: pops expectations whenever the DUT pushes, pops or completes a read.
  initial begin
    logic    m_pend;
    rd_exp_t e;
    m_pend = 1'b0;
    forever begin
      @(negedge HCLK);
      if (!HRESETn) begin
        m_pend = 1'b0;
        exp_rd_q.delete();
      end else begin
        if (CFIFO_WEN) begin
          if (exp_cmd_q.size() == 0) flag_fail("cmd_push");
          else check("cmd_word", {29'h0, CFIFO_WDATA}, {29'h0, exp_cmd_q.pop_front()});
        end
        if (CFIFO_WEN || WFIFO_WEN)
          check("wen_pair", {63'h0, WFIFO_WEN}, {63'h0, CFIFO_WEN & CFIFO_WDATA[34]});
        if (WFIFO_WEN) begin
          if (exp_wd_q.size() == 0) flag_fail("wdata_push");
          else check("wdata_word", {32'h0, WFIFO_WDATA}, {32'h0, exp_wd_q.pop_front()});
        end
        if (RFIFO_REN) ren_cnt++;
        if (m_pend && HREADYOUT) begin
          if (exp_rd_q.size() == 0) flag_fail("rd_complete");
          else begin
            e = exp_rd_q.pop_front();
            check("rd_hresp", {63'h0, HRESP}, {63'h0, e.err});
            if (!e.err) check("rd_hrdata", {32'h0, HRDATA}, {32'h0, e.data});
          end
          m_pend = 1'b0;
        end
        if (HSEL && HREADY && HTRANS[1] && !HWRITE) m_pend = 1'b1;
      end
    end
  end

  // Read FIFO model: data appears rd_delay empty cycles after a read command is pushed.
  initial begin
    logic s_cmd, s_ren, armed;
    int   cnt;
    armed = 1'b0;
    cnt = 0;
    RFIFO_REMPTY = 1'b1;
    RFIFO_RDATA  = 32'h0;
    forever begin
      @(negedge HCLK);
      s_cmd = HRESETn && CFIFO_WEN && !CFIFO_WDATA[34];
      s_ren = RFIFO_REN;
      @(posedge HCLK);
      #1;
      if (!HRESETn) begin
        armed = 1'b0;
        RFIFO_REMPTY = 1'b1;
        rf_data_q.delete();
      end else begin
        if (s_ren) RFIFO_REMPTY = 1'b1;
        if (s_cmd) begin
          armed = 1'b1;
          cnt = rd_delay;
        end
        if (armed) begin
          if (cnt == 0) begin
            if (rf_data_q.size() > 0) RFIFO_RDATA = rf_data_q.pop_front();
            RFIFO_REMPTY = 1'b0;
            armed = 1'b0;
          end else begin
            cnt--;
          end
        end
      end
    end
  end

  task automatic wait_ready(input string name, output int waits);
    logic r;
    waits = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge HCLK);
      r = HREADY;
      @(posedge HCLK);
      #1;
      if (r) return;
      waits++;
    end
    flag_fail(name);
  endtask

  task automatic addr_phase(input logic wr, input logic [31:0] addr, input logic [2:0] size);
    int w;
    HSEL = 1'b1;
    HTRANS = 2'b10;
    HWRITE = wr;
    HADDR = addr;
    HSIZE = size;
    wait_ready("addr_timeout", w);
    HSEL = 1'b0;
    HTRANS = 2'b00;
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [2:0] size, input logic [31:0] data,
                          input logic [34:0] cmd, output int waits);
    exp_cmd_q.push_back(cmd);
    exp_wd_q.push_back(data);
    addr_phase(1'b1, addr, size);
    HWDATA = data;
    wait_ready("wdata_timeout", waits);
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [2:0] size, input logic [34:0] cmd,
                         input logic [31:0] data, input int delay, output int waits);
    rd_exp_t e;
    rd_delay = delay;
    rf_data_q.push_back(data);
    exp_cmd_q.push_back(cmd);
    e.err = 1'b0;
    e.data = data;
    exp_rd_q.push_back(e);
    addr_phase(1'b0, addr, size);
    wait_ready("rdata_timeout", waits);
  endtask

  task automatic bp_write(input logic use_wfull, input int ncyc, input logic [31:0] addr,
                          input logic [31:0] data, input logic [34:0] cmd);
    int w;
    exp_cmd_q.push_back(cmd);
    exp_wd_q.push_back(data);
    addr_phase(1'b1, addr, 3'd2);
    HWDATA = data;
    if (use_wfull) WFIFO_WFULL = 1'b1;
    else CFIFO_WFULL = 1'b1;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge HCLK);
      check("bp_hreadyout", {63'h0, HREADYOUT}, 64'h0);
      check("bp_cwen", {63'h0, CFIFO_WEN}, 64'h0);
      check("bp_wwen", {63'h0, WFIFO_WEN}, 64'h0);
      @(posedge HCLK);
      #1;
    end
    CFIFO_WFULL = 1'b0;
    WFIFO_WFULL = 1'b0;
    wait_ready("bp_timeout", w);
    check("bp_release_waits", w, 0);
  endtask

  initial begin
    int      w;
    int      ren0;
    rd_exp_t e;
    HRESETn = 1'b0;
    HADDR = 32'h0; HBURST = 3'h0; HSEL = 1'b0; HSIZE = 3'h0; HTRANS = 2'b00;
    HWDATA = 32'h0; HWRITE = 1'b0; CFIFO_WFULL = 1'b0; WFIFO_WFULL = 1'b0;
    repeat (2) @(posedge HCLK);
    @(negedge HCLK);
    check("rst_hreadyout", {63'h0, HREADYOUT}, 64'h1);
    check("rst_hresp", {63'h0, HRESP}, 64'h0);
    check("rst_hrdata", {32'h0, HRDATA}, 64'h0);
    check("rst_cwen", {63'h0, CFIFO_WEN}, 64'h0);
    check("rst_wwen", {63'h0, WFIFO_WEN}, 64'h0);
    check("rst_ren", {63'h0, RFIFO_REN}, 64'h0);
    check("rst_cmd", {29'h0, CFIFO_WDATA}, 64'h0);
    HRESETn = 1'b1;
    @(posedge HCLK);
    #1;

    do_write(32'h0000_0100, 3'd2, 32'hDEAD_BEEF, 35'h6_0000_0100, w);
    check("wr_waits", w, 0);

    ren0 = ren_cnt;
    do_read(32'h0000_0100, 3'd2, 35'h2_0000_0100, 32'hCAFE_F00D, 5, w);
    check("rd_waits", w, 7);
    check("rd_ren_pulses", ren_cnt - ren0, 1);

    do_write(32'h0000_0102, 3'd1, 32'h1234_5678, 35'h5_0000_0102, w);
    check("hw_wr_waits", w, 0);
    check("hrdata_hold", {32'h0, HRDATA}, 64'hCAFE_F00D);

    bp_write(1'b0, 4, 32'h0000_0400, 32'h1122_3344, 35'h6_0000_0400);
    bp_write(1'b1, 2, 32'h0000_0404, 32'h5566_7788, 35'h6_0000_0404);

    // Pipelined write then read to the same address.
    exp_cmd_q.push_back(35'h6_0000_0200);
    exp_wd_q.push_back(32'hA5A5_5A5A);
    exp_cmd_q.push_back(35'h2_0000_0200);
    rf_data_q.push_back(32'hA5A5_5A5A);
    e.err = 1'b0;
    e.data = 32'hA5A5_5A5A;
    exp_rd_q.push_back(e);
    rd_delay = 0;
    addr_phase(1'b1, 32'h0000_0200, 3'd2);
    HWDATA = 32'hA5A5_5A5A;
    addr_phase(1'b0, 32'h0000_0200, 3'd2);
    wait_ready("b2b_timeout", w);
    check("b2b_rd_waits", w, 2);

    // Reset while the read is parked in S_RWAIT.
    rd_delay = 20;
    exp_cmd_q.push_back(35'h2_0000_0300);
    rf_data_q.push_back(32'h7777_7777);
    addr_phase(1'b0, 32'h0000_0300, 3'd2);
    repeat (2) @(posedge HCLK);
    #3;
    ren0 = ren_cnt;
    HRESETn = 1'b0;
    #1;
    check("arst_hreadyout", {63'h0, HREADYOUT}, 64'h1);
    check("arst_hrdata", {32'h0, HRDATA}, 64'h0);
    check("arst_ren", {63'h0, RFIFO_REN}, 64'h0);
    check("arst_cwen", {63'h0, CFIFO_WEN}, 64'h0);
    @(posedge HCLK);
    @(negedge HCLK);
    HRESETn = 1'b1;
    @(posedge HCLK);
    #1;
    check("arst_no_ren", ren_cnt - ren0, 0);
    do_read(32'h0000_0104, 3'd2, 35'h2_0000_0104, 32'h0BAD_CAFE, 1, w);
    check("post_rst_rd_waits", w, 3);

`ifdef AHB_LITE_SDRAM_ERR_EN
    e.err = 1'b1;
    e.data = 32'h0;
    exp_rd_q.push_back(e);
    addr_phase(1'b0, 32'h0000_0102, 3'd2);
    @(negedge HCLK);
    check("err1_hreadyout", {63'h0, HREADYOUT}, 64'h0);
    check("err1_hresp", {63'h0, HRESP}, 64'h1);
    @(posedge HCLK);
    @(negedge HCLK);
    check("err2_hreadyout", {63'h0, HREADYOUT}, 64'h1);
    check("err2_hresp", {63'h0, HRESP}, 64'h1);
    @(posedge HCLK);
    @(negedge HCLK);
    check("err_done_hresp", {63'h0, HRESP}, 64'h0);
    @(posedge HCLK);
    #1;
`endif

    repeat (3) @(posedge HCLK);
    #1;
    check("cmd_q_drained", exp_cmd_q.size(), 0);
    check("wd_q_drained", exp_wd_q.size(), 0);
    check("rd_q_drained", exp_rd_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
